// File: rtl/dpram_block_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_block_reader_pkg : reader states, default dpram geometry, room check
// Revision 1.0
// ---------------------------------------------------------------------------
package dpram_block_reader_pkg;

   localparam int DEFAULT_ADDR_W = 7;
   localparam int DEFAULT_DATA_W = 8;

   typedef logic [1:0] rd_state_t;

   localparam rd_state_t ST_IDLE  = 2'd0;
   localparam rd_state_t ST_READ  = 2'd1;
   localparam rd_state_t ST_DRAIN = 2'd2;

   // A new read may issue only if the 2-deep buffer can hold it plus the one already
   // in flight, assuming no pop beyond the one happening this cycle.
   function automatic logic fifo_can_accept(input logic [1:0] count,
                                            input logic       in_flight,
                                            input logic       popping);
      logic [2:0] need;
      need = {1'b0, count} + {2'b00, in_flight} + 3'd1;
      return need <= (3'd2 + {2'b00, popping});
   endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_block_reader_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skid_fifo2 : 2-entry valid/ready FIFO with exposed occupancy (0..2)
// Revision 1.0
// ---------------------------------------------------------------------------
module skid_fifo2
   import dpram_block_reader_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      push     = in_valid && in_ready;
      pop      = out_valid && out_ready;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dpram_block_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_block_reader : streams a block of dpram bytes out through a skid FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module dpram_block_reader
   import dpram_block_reader_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_wren,
   output logic              ram_byteena,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        issue_cnt_q, issue_cnt_d;
   logic [7:0]        emit_cnt_q, emit_cnt_d;
   logic              in_flight_q, in_flight_d;
   logic              done_q, done_d;

   logic [1:0]        fifo_count;
   logic              fifo_ready_unused;
   logic              handshake;
   logic              issue;
   logic [7:0]        issue_next;
   logic [7:0]        emit_next;

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign ram_address = addr_q;
   assign ram_wren    = 1'b0;
   assign ram_byteena = 1'b1;

   // Buffer room is guaranteed by the issue check, so its in_ready is never consulted.
   skid_fifo2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_flight_q),
      .in_data   (ram_q),
      .in_ready  (fifo_ready_unused),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (fifo_count)
   );

   always_comb begin
      handshake   = out_valid && out_ready;
      issue_next  = issue_cnt_q + 8'd1;
      emit_next   = emit_cnt_q + 8'd1;
      issue       = (state_q == ST_READ) && (issue_cnt_q != len_q) &&
                    fifo_can_accept(fifo_count, in_flight_q, handshake);

      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      emit_cnt_d  = handshake ? emit_next : emit_cnt_q;
      in_flight_d = issue;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // done_q blocks a start landing on the completion pulse
            if (start && !done_q) begin
               if (length == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = ST_READ;
                  addr_d      = start_addr;
                  len_d       = length;
                  issue_cnt_d = 8'd0;
                  emit_cnt_d  = 8'd0;
               end
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d      = addr_q + ADDR_W'(1);
               issue_cnt_d = issue_next;
               if (issue_next == len_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (handshake && (emit_next == len_q)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= 8'd0;
         issue_cnt_q <= 8'd0;
         emit_cnt_q  <= 8'd0;
         in_flight_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         emit_cnt_q  <= emit_cnt_d;
         in_flight_q <= in_flight_d;
         done_q      <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/dpram_block_reader.md
DPRAM_BLOCK_READER -- requirements
Module: dpram_block_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, RAM address width (128 entries).
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have one clock and one reset, where the reset is asynchronous and active-low.
REQ-004 The ports SHALL be, in order:
- clock  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a block read
- start_addr  in  ADDR_W  first RAM address of the block
- length  in  8  number of bytes to read (0..255)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last byte has been accepted downstream
- ram_address  out  ADDR_W  drives the dpram read port address
- ram_wren  out  1  dpram write enable, constant 0
- ram_byteena  out  1  dpram byte enable, constant 1
- ram_q  in  DATA_W  dpram read data, valid one cycle after ram_address
- out_data  out  DATA_W  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high

Function
REQ-005 The block SHALL implement the states IDLE, READ and DRAIN.
REQ-006 In IDLE, start=1 SHALL latch start_addr and length, assert busy on the next cycle, and enter READ. If length=0, it SHALL instead pulse done on the next cycle, keep busy low, and stay in IDLE.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 In READ, the block SHALL issue one RAM read per cycle whenever the output buffer has room for the issued read plus any read in flight; otherwise it SHALL hold ram_address.
REQ-009 RAM read latency SHALL be exactly 1 cycle: ram_q sampled at edge N+1 belongs to the address driven during cycle N.
REQ-010 The address SHALL increment by 1 per issued read and wrap from 127 to 0 modulo 2^ADDR_W.
- Lengths above 128 re-read wrapped entries.
REQ-011 The output buffer SHALL be a 2-entry FIFO (skid), so that full throughput of one byte per cycle is sustained while out_ready=1.
REQ-012 With out_ready held at 1, the first out_valid SHALL rise 2 cycles after the start edge, and bytes SHALL follow on consecutive cycles.
REQ-013 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 out_valid SHALL NOT drop without a handshake.
REQ-015 Bytes SHALL emerge in address order with no duplication or loss under any out_ready pattern.
REQ-016 After the last read is issued, the block SHALL enter DRAIN, and it SHALL remain there until the FIFO is empty and no read is in flight.
REQ-017 done SHALL pulse in the cycle after the final handshake, busy SHALL fall in that same cycle, and the state SHALL return to IDLE.
REQ-018 A start arriving in the same cycle that done pulses SHALL be ignored; a start one cycle later SHALL be accepted.
REQ-019 The issued-read counter and the emitted-byte counter SHALL each be 8 bits, and neither SHALL overflow for length=255.

Reset
REQ-020 While reset_n=0, the block SHALL immediately force the following, regardless of clock: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, ram_address=0, FIFO empty, counters 0.
REQ-021 A reset asserted mid-transfer SHALL abort the transfer with no done pulse, and the block SHALL accept a new start on the first edge after reset_n rises.
REQ-022 ram_wren=0 and ram_byteena=1 SHALL hold in all states, including during reset.

Structure
REQ-023 The state enumeration (IDLE/READ/DRAIN) and the default ADDR_W/DATA_W constants SHALL live in a shared package reused by dpram clients.
REQ-024 The 2-entry skid FIFO SHALL be a separate sub-module named skid_fifo2, with DATA_W-wide valid/ready on both sides and an internal occupancy count of 0..2.
REQ-025 The bench SHALL instantiate the existing dpram, with port A used by the bench as writer and port B driven by this block.

Verification
REQ-026 Bench scenario 1: preload ram[i]=i; start_addr=0x10, length=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles, first at start+2; done at start+6.
REQ-027 Bench scenario 2: start_addr=0x7E, length=4 -> out_data 0x7E,0x7F,0x00,0x01 (address wrap).
REQ-028 Bench scenario 3: length=8, out_ready toggled 1,0,0,1,0,1... -> all 8 bytes emitted in order, and out_data stays stable during stalls.
REQ-029 Bench scenario 4: length=0 -> done pulses 1 cycle after start, busy stays 0, and out_valid never rises.
REQ-030 Bench scenario 5: reset_n pulsed low after 3 of 10 bytes -> outputs reach reset values immediately with no done pulse; a new start with length=2 then completes normally.
REQ-031 Bench scenario 6: start re-pulsed while busy, and on the done cycle -> both ignored; length=255 from 0 -> 255 bytes emitted, byte k = k mod 128.
